// File: rtl/timer_irq_unit.sv
// timer_irq_unit
// Memory-mapped timer and interrupt source on the MEM-stage bus of the
// pipelined MIPS core. It sits alongside the data memory.
//
// Register window (word aligned, Address[1:0] ignored):
//   BASE+0x00 TH      reload value, R/W
//   BASE+0x04 TL      count, R/W
//   BASE+0x08 TCON    {OS, ST, IE, EN} in bits [3:0], R/W; upper bits read 0
//   BASE+0x0C         unmapped
//   BASE+0x10 systick free-running cycle counter, read-only
//
// Ports:
//   clk         core clock
//   reset       synchronous, active-high; clears all state
//   MemRead     MEM-stage load strobe
//   MemWrite    MEM-stage store strobe
//   Address     MEM-stage byte address
//   Write_data  MEM-stage store data
//   Read_data   combinational load data; 0 unless a mapped read is active
//   kernel      PC[31] of the fetch PC; masks IRQ while high
//   IRQ         timer interrupt request (IE & ST & ~kernel)
//   systick     free-running cycle counter
`timescale 1ns/1ps

module timer_irq_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  input  logic        kernel,
  output logic        IRQ,
  output logic [31:0] systick
);

  // Prescaler width; a PRESCALE of 1 still needs a one-bit counter so the
  // compare below stays well formed.
  localparam int            PCW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

  logic [31:0]    r_th;
  logic [31:0]    r_tl;
  logic           r_en;
  logic           r_ie;
  logic           r_st;
  logic           r_os;
  logic [PCW-1:0] r_pc;
  logic [31:0]    r_systick;

  logic [31:0] w_offset;
  logic [2:0]  w_word;
  logic        w_inWindow;
  logic        w_selTh;
  logic        w_selTl;
  logic        w_selTcon;
  logic        w_selSys;
  logic        w_wrTh;
  logic        w_wrTl;
  logic        w_wrTcon;
  logic        w_tick;
  logic        w_overflow;
  logic        w_ovfSet;
  logic [1:0]  w_unused_addrLow;

  // Byte-offset bits are deliberately ignored by the decoder.
  assign w_unused_addrLow = Address[1:0];

  // Decode relative to the base so the window may sit at any aligned base.
  // Offsets 0x00..0x1F are inside; word 3 and words 5..7 are unmapped.
  assign w_offset   = {Address[31:2], 2'b00} - BASE_ADDR;
  assign w_inWindow = (w_offset[31:5] == 27'd0);
  assign w_word     = w_offset[4:2];
  assign w_selTh    = w_inWindow && (w_word == 3'd0);
  assign w_selTl    = w_inWindow && (w_word == 3'd1);
  assign w_selTcon  = w_inWindow && (w_word == 3'd2);
  assign w_selSys   = w_inWindow && (w_word == 3'd4);

  assign w_wrTh   = MemWrite && w_selTh;
  assign w_wrTl   = MemWrite && w_selTl;
  assign w_wrTcon = MemWrite && w_selTcon;

  // A tick is the last cycle of each enabled prescale period.
  assign w_tick     = r_en && (r_pc == PC_LAST);
  assign w_overflow = w_tick && (r_tl == 32'hFFFFFFFF);
  assign w_ovfSet   = w_overflow && r_ie;

  always_comb begin
    Read_data = 32'd0;
    if (MemRead) begin
      if (w_selTh)   Read_data = r_th;
      if (w_selTl)   Read_data = r_tl;
      if (w_selTcon) Read_data = {28'd0, r_os, r_st, r_ie, r_en};
      if (w_selSys)  Read_data = r_systick;
    end
  end

  assign IRQ     = r_ie && r_st && !kernel;
  assign systick = r_systick;

  // Prescaler restarts from zero whenever counting is disabled, so a
  // re-enable always begins a full period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
    end else if (!r_en || w_tick) begin
      r_pc <= '0;
    end else begin
      r_pc <= r_pc + 1'b1;
    end
  end

  // CPU writes to TH/TL take priority over hardware reload/increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_th <= 32'd0;
      r_tl <= 32'd0;
    end else begin
      if (w_wrTh) r_th <= Write_data;
      if (w_wrTl) begin
        r_tl <= Write_data;
      end else if (w_tick) begin
        r_tl <= w_overflow ? r_th : r_tl + 32'd1;
      end
    end
  end

  // A one-shot overflow forces EN low even over a software write, and a
  // hardware status set is ORed in so a software clear can never lose it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en <= 1'b0;
      r_ie <= 1'b0;
      r_st <= 1'b0;
      r_os <= 1'b0;
    end else begin
      r_en <= (w_wrTcon ? Write_data[0] : r_en) && !(w_overflow && r_os);
      r_ie <= w_wrTcon ? Write_data[1] : r_ie;
      r_st <= (w_wrTcon ? Write_data[2] : r_st) || w_ovfSet;
      r_os <= w_wrTcon ? Write_data[3] : r_os;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_systick <= 32'd0;
    end else begin
      r_systick <= r_systick + 32'd1;
    end
  end

endmodule

// File: tb/tb_timer_irq_unit.sv
`timescale 1ns/1ps

module tb_timer_irq_unit;

  localparam logic [31:0] BASE = 32'h40000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, kernel, IRQ;
  logic [31:0] Address, Write_data, Read_data, systick;
  logic        p_MemRead, p_MemWrite, p_kernel, p_IRQ;
  logic [31:0] p_Address, p_Write_data, p_Read_data, p_systick;

  int          total = 0;
  int          bad = 0;
  logic [31:0] expTick;
  logic [31:0] v;

  timer_irq_unit #(.BASE_ADDR(BASE), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
    .kernel(kernel), .IRQ(IRQ), .systick(systick)
  );

  timer_irq_unit #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .MemRead(p_MemRead), .MemWrite(p_MemWrite),
    .Address(p_Address), .Write_data(p_Write_data), .Read_data(p_Read_data),
    .kernel(p_kernel), .IRQ(p_IRQ), .systick(p_systick)
  );

  always #5 clk = ~clk;

  // Reference cycle counter for systick.
  always @(posedge clk) expTick <= reset ? 32'd0 : expTick + 32'd1;

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    Address = a; Write_data = d; MemWrite = 1'b1;
    @(posedge clk);
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    Address = a; MemRead = 1'b1;
    #1;
    d = Read_data;
    MemRead = 1'b0;
  endtask

  task automatic p4Write(input logic [31:0] a, input logic [31:0] d);
    p_Address = a; p_Write_data = d; p_MemWrite = 1'b1;
    @(posedge clk);
    @(negedge clk);
    p_MemWrite = 1'b0;
  endtask

  task automatic p4Read(input logic [31:0] a, output logic [31:0] d);
    p_Address = a; p_MemRead = 1'b1;
    #1;
    d = p_Read_data;
    p_MemRead = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; kernel = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Address = 32'd0; Write_data = 32'd0;
    p_kernel = 1'b0; p_MemRead = 1'b0; p_MemWrite = 1'b0;
    p_Address = 32'd0; p_Write_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    busRead(BASE + 32'h0, v);
    total++; if (v !== 32'd0) begin bad++; $display("[TB] FAIL reset_th: got %h want %h", v, 32'd0); end
    busRead(BASE + 32'h4, v);
    total++; if (v !== 32'd0) begin bad++; $display("[TB] FAIL reset_tl: got %h want %h", v, 32'd0); end
    busRead(BASE + 32'h8, v);
    total++; if (v !== 32'd0) begin bad++; $display("[TB] FAIL reset_tcon: got %h want %h", v, 32'd0); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq: got %b want 0", IRQ); end
    total++; if (systick !== 32'd0) begin bad++; $display("[TB] FAIL reset_systick0: got %h want 0", systick); end
    @(negedge clk);
    total++; if (systick !== 32'd1) begin bad++; $display("[TB] FAIL reset_systick1: got %h want 1", systick); end
    busRead(BASE + 32'hC, v);
    total++; if (v !== 32'd0) begin bad++; $display("[TB] FAIL reset_unmapped: got %h want 0", v); end
  endtask

  task automatic test_reload_irq();
    busWrite(BASE + 32'h0, 32'hFFFFFFFD);
    busWrite(BASE + 32'h4, 32'hFFFFFFFE);
    busWrite(BASE + 32'h8, 32'h3);
    busRead(BASE + 32'h4, v);
    total++; if (v !== 32'hFFFFFFFE) begin bad++; $display("[TB] FAIL reload_tl0: got %h want %h", v, 32'hFFFFFFFE); end
    @(negedge clk);
    busRead(BASE + 32'h4, v);
    total++; if (v !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL reload_tl1: got %h want %h", v, 32'hFFFFFFFF); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("[TB] FAIL reload_irq_early: got %b want 0", IRQ); end
    @(negedge clk);
    busRead(BASE + 32'h4, v);
    total++; if (v !== 32'hFFFFFFFD) begin bad++; $display("[TB] FAIL reload_tl2: got %h want %h", v, 32'hFFFFFFFD); end
    busRead(BASE + 32'h8, v);
    total++; if (v !== 32'h7) begin bad++; $display("[TB] FAIL reload_tcon: got %h want %h", v, 32'h7); end
    total++; if (IRQ !== 1'b1) begin bad++; $display("[TB] FAIL reload_irq: got %b want 1", IRQ); end
    @(negedge clk);
    busRead(BASE + 32'h4, v);
    total++; if (v !== 32'hFFFFFFFE) begin bad++; $display("[TB] FAIL reload_tl3: got %h want %h", v, 32'hFFFFFFFE); end
  endtask

  task automatic test_kernel_mask();
    kernel = 1'b1;
    #1;
    total++; if (IRQ !== 1'b0) begin bad++; $display("[TB] FAIL kernel_mask: got %b want 0", IRQ); end
    kernel = 1'b0;
    #1;
    total++; if (IRQ !== 1'b1) begin bad++; $display("[TB] FAIL kernel_unmask: got %b want 1", IRQ); end
  endtask

  // TL is 0xFFFFFFFE and counting on entry, so the first ack sees no
  // overflow and the second lands exactly on the overflow tick.
  task automatic test_ack_race();
    busWrite(BASE + 32'h8, 32'h3);
    total++; if (IRQ !== 1'b0) begin bad++; $display("[TB] FAIL ack_irq: got %b want 0", IRQ); end
    busRead(BASE + 32'h8, v);
    total++; if (v !== 32'h3) begin bad++; $display("[TB] FAIL ack_tcon: got %h want %h", v, 32'h3); end
    busWrite(BASE + 32'h8, 32'h3);
    busRead(BASE + 32'h8, v);
    total++; if (v !== 32'h7) begin bad++; $display("[TB] FAIL race_tcon: got %h want %h", v, 32'h7); end
    total++; if (IRQ !== 1'b1) begin bad++; $display("[TB] FAIL race_irq: got %b want 1", IRQ); end
    busRead(BASE + 32'h4, v);
    total++; if (v !== 32'hFFFFFFFD) begin bad++; $display("[TB] FAIL race_tl: got %h want %h", v, 32'hFFFFFFFD); end
  endtask

  task automatic test_one_shot();
    busWrite(BASE + 32'h8, 32'h0);
    busWrite(BASE + 32'h0, 32'h5);
    busWrite(BASE + 32'h4, 32'hFFFFFFFF);
    busWrite(BASE + 32'h8, 32'hB);
    @(negedge clk);
    busRead(BASE + 32'h8, v);
    total++; if (v !== 32'hE) begin bad++; $display("[TB] FAIL oneshot_tcon: got %h want %h", v, 32'hE); end
    busRead(BASE + 32'h4, v);
    total++; if (v !== 32'h5) begin bad++; $display("[TB] FAIL oneshot_tl: got %h want %h", v, 32'h5); end
    repeat (10) @(negedge clk);
    busRead(BASE + 32'h4, v);
    total++; if (v !== 32'h5) begin bad++; $display("[TB] FAIL oneshot_hold: got %h want %h", v, 32'h5); end
  endtask

  // State on entry: TH=5, TL=5, TCON=0xE (stopped, ST pending).
  task automatic test_decode();
    busRead(BASE + 32'h7, v);
    total++; if (v !== 32'h5) begin bad++; $display("[TB] FAIL decode_lowbits: got %h want %h", v, 32'h5); end
    busRead(BASE + 32'h10, v);
    total++; if (v !== expTick) begin bad++; $display("[TB] FAIL decode_systick_rd: got %h want %h", v, expTick); end
    Address = BASE; MemRead = 1'b0;
    #1;
    total++; if (Read_data !== 32'd0) begin bad++; $display("[TB] FAIL decode_noread: got %h want 0", Read_data); end
    busWrite(BASE + 32'hC, 32'hDEAD0001);
    busWrite(BASE + 32'h10, 32'hDEAD0002);
    busWrite(BASE + 32'h20, 32'hDEAD0003);
    busWrite(32'h00000000, 32'hDEAD0004);
    busRead(BASE + 32'h0, v);
    total++; if (v !== 32'h5) begin bad++; $display("[TB] FAIL decode_th_kept: got %h want %h", v, 32'h5); end
    busRead(BASE + 32'h8, v);
    total++; if (v !== 32'hE) begin bad++; $display("[TB] FAIL decode_tcon_kept: got %h want %h", v, 32'hE); end
    total++; if (systick !== expTick) begin bad++; $display("[TB] FAIL decode_systick: got %h want %h", systick, expTick); end
    busRead(BASE + 32'h20, v);
    total++; if (v !== 32'd0) begin bad++; $display("[TB] FAIL decode_outside: got %h want 0", v); end
    busWrite(BASE + 32'h8, 32'hFFFFFFF0);
    busRead(BASE + 32'h8, v);
    total++; if (v !== 32'h0) begin bad++; $display("[TB] FAIL tcon_upper: got %h want 0", v); end
    busWrite(BASE + 32'h8, 32'hFFFFFFFF);
    busRead(BASE + 32'h8, v);
    total++; if (v !== 32'hF) begin bad++; $display("[TB] FAIL tcon_all: got %h want %h", v, 32'hF); end
    total++; if (IRQ !== 1'b1) begin bad++; $display("[TB] FAIL tcon_all_irq: got %b want 1", IRQ); end
  endtask

  task automatic test_prescaler();
    p4Write(BASE + 32'h4, 32'h0);
    p4Write(BASE + 32'h8, 32'h1);
    repeat (3) @(negedge clk);
    p4Read(BASE + 32'h4, v);
    total++; if (v !== 32'd0) begin bad++; $display("[TB] FAIL pre_3: got %h want 0", v); end
    @(negedge clk);
    p4Read(BASE + 32'h4, v);
    total++; if (v !== 32'd1) begin bad++; $display("[TB] FAIL pre_4: got %h want 1", v); end
    repeat (4) @(negedge clk);
    p4Read(BASE + 32'h4, v);
    total++; if (v !== 32'd2) begin bad++; $display("[TB] FAIL pre_8: got %h want 2", v); end
    repeat (2) @(negedge clk);
    p4Write(BASE + 32'h8, 32'h0);
    p4Write(BASE + 32'h8, 32'h1);
    repeat (3) @(negedge clk);
    p4Read(BASE + 32'h4, v);
    total++; if (v !== 32'd2) begin bad++; $display("[TB] FAIL pre_restart3: got %h want 2", v); end
    @(negedge clk);
    p4Read(BASE + 32'h4, v);
    total++; if (v !== 32'd3) begin bad++; $display("[TB] FAIL pre_restart4: got %h want 3", v); end
    total++; if (p_IRQ !== 1'b0) begin bad++; $display("[TB] FAIL pre_irq: got %b want 0", p_IRQ); end
    total++; if (p_systick !== expTick) begin bad++; $display("[TB] FAIL pre_systick: got %h want %h", p_systick, expTick); end
  endtask

  // Entered with the timer running and ST pending.
  task automatic test_reset_midcount();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++; if (IRQ !== 1'b0) begin bad++; $display("[TB] FAIL mid_irq: got %b want 0", IRQ); end
    busRead(BASE + 32'h4, v);
    total++; if (v !== 32'd0) begin bad++; $display("[TB] FAIL mid_tl: got %h want 0", v); end
    busRead(BASE + 32'h8, v);
    total++; if (v !== 32'd0) begin bad++; $display("[TB] FAIL mid_tcon: got %h want 0", v); end
    total++; if (systick !== 32'd0) begin bad++; $display("[TB] FAIL mid_systick: got %h want 0", systick); end
    @(negedge clk);
    busRead(BASE + 32'h4, v);
    total++; if (v !== 32'd0) begin bad++; $display("[TB] FAIL mid_tl_stopped: got %h want 0", v); end
  endtask

  initial begin
    test_reset();
    test_reload_irq();
    test_kernel_mask();
    test_ack_race();
    test_one_shot();
    test_decode();
    test_prescaler();
    test_reset_midcount();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
